// File: rtl/mdu_xlen.sv
// RV M-extension multiply/divide unit: iterative multiplier (MUL_STEP bits per cycle)
// and restoring divider, one operation in flight, valid/ready request and response.
module mdu_xlen #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, RESP} state_t;
    state_t state_reg, state_next;

    logic [2:0]          funct3_reg;
    logic [TAG_W-1:0]    tag_reg;
    logic                a_neg_reg;
    logic                res_neg_reg;
    logic                special_reg;
    logic [CW-1:0]       count_reg;
    logic [2*XLEN-1:0]   acc_reg;
    logic [2*XLEN-1:0]   mcand_reg;
    logic [XLEN-1:0]     mplier_reg;
    logic [XLEN-1:0]     resp_data_reg;

    logic                accept;
    logic                in_is_div, a_signed, b_signed, a_neg_in, b_neg_in;
    logic [XLEN-1:0]     a_abs_in, b_abs_in, special_val;
    logic                b_zero, ovf, special_in;

    assign req_ready  = (state_reg == IDLE) && !flush;
    assign busy       = (state_reg != IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_data  = resp_data_reg;
    assign resp_tag   = tag_reg;
    assign accept     = req_valid && req_ready;

    // funct3[2] selects divide; among divides funct3[0]=0 is the signed flavour
    assign in_is_div = req_funct3[2];
    assign a_signed  = in_is_div ? !req_funct3[0] : (req_funct3[1:0] == 2'b01 || req_funct3[1:0] == 2'b10);
    assign b_signed  = in_is_div ? !req_funct3[0] : (req_funct3[1:0] == 2'b01);
    assign a_neg_in  = a_signed && req_a[XLEN-1];
    assign b_neg_in  = b_signed && req_b[XLEN-1];
    assign a_abs_in  = a_neg_in ? (~req_a + 1'b1) : req_a;
    assign b_abs_in  = b_neg_in ? (~req_b + 1'b1) : req_b;

    assign b_zero     = (req_b == '0);
    assign ovf        = !req_funct3[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b);
    assign special_in = in_is_div && (b_zero || ovf);
    assign special_val = b_zero ? (req_funct3[1] ? req_a : '1)
                                : (req_funct3[1] ? '0 : req_a);

    // Multiplier: one shifted copy of the multiplicand per retired multiplier bit
    logic [2*XLEN-1:0] pp [MUL_STEP];
    logic [2*XLEN-1:0] mul_sum;
    genvar gi;
    generate
        for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        mul_sum = acc_reg;
        for (int i = 0; i < MUL_STEP; i++) begin
            mul_sum = mul_sum + pp[i];
        end
    end

    // Divider: acc_reg holds {remainder, dividend/quotient}, divisor sits in mplier_reg
    logic [XLEN:0]     rem_shift, div_diff;
    logic [2*XLEN-1:0] div_next;
    assign rem_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_diff  = rem_shift - {1'b0, mplier_reg};
    assign div_next  = {div_diff[XLEN] ? rem_shift[XLEN-1:0] : div_diff[XLEN-1:0],
                        acc_reg[XLEN-2:0], ~div_diff[XLEN]};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem, fix_result;
    assign prod_fix = res_neg_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign quo      = acc_reg[XLEN-1:0];
    assign rem      = acc_reg[2*XLEN-1:XLEN];

    always_comb begin
        fix_result = prod_fix[XLEN-1:0];
        if (special_reg) begin
            fix_result = acc_reg[XLEN-1:0];
        end else begin
            case (funct3_reg)
                3'b000:                 fix_result = prod_fix[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fix_result = res_neg_reg ? (~quo + 1'b1) : quo;
                default:                fix_result = a_neg_reg ? (~rem + 1'b1) : rem;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = special_in ? FIX : CALC;
            CALC: if (count_reg == '0) state_next = FIX;
            FIX:  state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_reg    <= '0;
            tag_reg       <= '0;
            a_neg_reg     <= 1'b0;
            res_neg_reg   <= 1'b0;
            special_reg   <= 1'b0;
            count_reg     <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            resp_data_reg <= '0;
        end else if (accept) begin
            funct3_reg  <= req_funct3;
            tag_reg     <= req_tag;
            a_neg_reg   <= a_neg_in;
            res_neg_reg <= a_neg_in ^ b_neg_in;
            special_reg <= special_in;
            count_reg   <= in_is_div ? CW'(XLEN - 1) : CW'(XLEN / MUL_STEP - 1);
            mcand_reg   <= {{XLEN{1'b0}}, a_abs_in};
            mplier_reg  <= b_abs_in;
            if (special_in)     acc_reg <= {{XLEN{1'b0}}, special_val};
            else if (in_is_div) acc_reg <= {{XLEN{1'b0}}, a_abs_in};
            else                acc_reg <= '0;
        end else if (state_reg == CALC) begin
            count_reg <= count_reg - 1'b1;
            if (funct3_reg[2]) begin
                acc_reg <= div_next;
            end else begin
                acc_reg    <= mul_sum;
                mcand_reg  <= mcand_reg << MUL_STEP;
                mplier_reg <= mplier_reg >> MUL_STEP;
            end
        end else if (state_reg == FIX && !flush) begin
            resp_data_reg <= fix_result;
        end
    end
endmodule

// File: doc/mdu_xlen.md
MDU_XLEN -- requirements
Module: mdu_xlen

Interface
Parameters:
REQ-001 The block SHALL take parameter XLEN, default 32, as the operand and result width (legal values 32 or 64).
REQ-002 The block SHALL take parameter MUL_STEP, default 2, as the number of multiplier bits retired per cycle (legal values 1, 2 or 4; XLEN divisible by MUL_STEP).
REQ-003 The block SHALL take parameter TAG_W, default 5, as the width of the request/response tag (destination register id).

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port req_funct3, input, 3 bits: the RV M-extension operation (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-009 The block SHALL have ports req_a and req_b, input, XLEN bits each: rs1 and rs2.
REQ-010 The block SHALL have port req_tag, input, TAG_W bits: an opaque tag returned with the result.
REQ-011 The block SHALL have port flush, input, 1 bit: abort the current operation (pipeline kill).
REQ-012 The block SHALL have port resp_valid, output, 1 bit: a result is present.
REQ-013 The block SHALL have port resp_ready, input, 1 bit: the consumer takes the result.
REQ-014 The block SHALL have port resp_data, output, XLEN bits: the result.
REQ-015 The block SHALL have port resp_tag, output, TAG_W bits: the tag of the request that produced resp_data.
REQ-016 The block SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, CALC, FIX and RESP; req_ready SHALL equal (state==IDLE) && !flush.
REQ-018 On an accept (req_valid && req_ready at edge T), the block SHALL latch funct3, a, b and tag, and precompute operand signs and absolute values per funct3 signedness.
- MULH: a and b signed. MULHSU: a signed, b unsigned. DIV/REM: both signed. All other ops unsigned.
REQ-019 Special cases SHALL go IDLE->FIX directly with no iterations:
- DIV/DIVU with b==0: quotient all-ones.
- REM/REMU with b==0: remainder = a.
- DIV with a==most-negative and b==-1: quotient = a (most-negative).
- REM with a==most-negative and b==-1: remainder = 0.
REQ-020 All other ops SHALL go IDLE->CALC, and the state SHALL stay in CALC for N cycles, with N = XLEN/MUL_STEP for multiplies and N = XLEN for divides (restoring divide, one quotient bit per cycle).
REQ-021 In CALC, the multiplier SHALL add MUL_STEP partial products per cycle into a 2*XLEN accumulator of the unsigned magnitudes.
REQ-022 In FIX, the block SHALL apply sign correction and select the result, then move to RESP:
- MUL: low XLEN bits.
- MULH/MULHSU/MULHU: high XLEN bits, negated as a 2*XLEN value when the operand signs differ (MULHSU: when a<0).
- DIV: quotient negated when the signs differ.
- REM: remainder takes the sign of a.
REQ-023 Latency SHALL be measured from edge T: resp_valid asserts after edge T+N+1 (normal) or T+1 (special case).
REQ-024 In RESP, resp_valid, resp_data and resp_tag SHALL be held stable until resp_ready; on resp_valid && resp_ready the state SHALL return to IDLE at that edge.
REQ-025 A new request SHALL be accepted no earlier than the cycle after the handshake; the block SHALL process one operation in flight only.
REQ-026 flush SHALL force the state to IDLE at the next edge from any state, deassert resp_valid, and produce no response; flush concurrent with req_valid SHALL NOT accept the request.
REQ-027 An undefined funct3 SHALL NOT occur, because the encoding is 3 bits and every value is defined.

Reset
REQ-028 While rst_n is low, the block SHALL set state=IDLE, busy=0, resp_valid=0, resp_data=0 and resp_tag=0, and clear all internal registers; req_ready SHALL be 1 after release.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no response.

Verification (XLEN=32, MUL_STEP=2)
REQ-030 The bench SHALL drive MULH a=0xFFFFFFFE, b=3, tag=7 -> resp_data=0xFFFFFFFF, resp_tag=7, resp_valid after edge T+17.
REQ-031 The bench SHALL drive DIV a=-7, b=2, then REM with the same operands -> resp_data=0xFFFFFFFD (-3), then 0xFFFFFFFF (-1), each valid after edge T+33.
REQ-032 The bench SHALL drive DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5; both valid after edge T+1.
REQ-033 The bench SHALL drive DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0, valid after edge T+1.
REQ-034 The bench SHALL hold resp_ready low for 10 cycles after MULHU a=b=0xFFFFFFFF -> resp_data=0xFFFFFFFE held stable, busy=1, req_ready=0 throughout.
REQ-035 The bench SHALL pulse flush at CALC cycle 5 of a DIV -> IDLE next edge, no resp_valid, and a subsequent MUL a=6, b=7 returns 42.
